// File: rtl/sga_pkg.sv
// Shared constants for the Snake Game Arcade datapath: pixel codes, render
// state encodings and default board dimensions.
package sga_pkg;

  localparam int unsigned DEF_ROWS    = 16;
  localparam int unsigned DEF_COLS    = 16;
  localparam int unsigned DEF_COLOR_W = 2;

  localparam int unsigned PIX_EMPTY = 0;
  localparam int unsigned PIX_BODY  = 1;
  localparam int unsigned PIX_HEAD  = 2;
  localparam int unsigned PIX_APPLE = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } render_state_e;

endpackage

// File: rtl/sga_cell_classifier.sv
// Combinational cell classifier: head beats apple beats body beats empty.
module sga_cell_classifier
  import sga_pkg::*;
#(
  parameter int unsigned CELLS   = DEF_ROWS * DEF_COLS,
  parameter int unsigned AW      = $clog2(CELLS),
  parameter int unsigned COLOR_W = DEF_COLOR_W
) (
  input  logic [AW-1:0]      idx,
  input  logic [AW-1:0]      head,
  input  logic [AW-1:0]      apple,
  input  logic               apple_valid,
  input  logic [CELLS-1:0]   body_map,
  output logic [COLOR_W-1:0] color
);

  always_comb begin
    color = COLOR_W'(PIX_EMPTY);
    if (idx == head)                       color = COLOR_W'(PIX_HEAD);
    else if (apple_valid && idx == apple)  color = COLOR_W'(PIX_APPLE);
    else if (body_map[idx])                color = COLOR_W'(PIX_BODY);
  end

endmodule

// File: rtl/sga_render_engine.sv
// Frame renderer: walks board cells in raster order under credit control from
// the control unit and writes each classified cell over a valid/ready port.
module sga_render_engine
  import sga_pkg::*;
#(
  parameter int unsigned ROWS    = DEF_ROWS,
  parameter int unsigned COLS    = DEF_COLS,
  parameter int unsigned COLOR_W = DEF_COLOR_W,
  localparam int unsigned CELLS  = ROWS * COLS,
  localparam int unsigned AW     = $clog2(CELLS)
) (
  input  logic               clock,
  input  logic               restart,
  input  logic               render_clr,
  input  logic               render_count,
  input  logic [AW-1:0]      head_pos,
  input  logic [AW-1:0]      apple_pos,
  input  logic               apple_valid,
  input  logic [CELLS-1:0]   body_map,
  input  logic               fb_ready,
  output logic               fb_valid,
  output logic [AW-1:0]      fb_addr,
  output logic [COLOR_W-1:0] fb_color,
  output logic               render_finish,
  output logic [1:0]         db_state
);

  localparam logic [AW-1:0] LAST = AW'(CELLS - 1);

  render_state_e state_q, state_n;
  logic [AW-1:0] idx_q, idx_n;
  logic [AW-1:0] cred_q, cred_n;
  logic [AW-1:0] head_q, head_n, apple_q, apple_n;
  logic          av_q, av_n;
  logic          adv, inc;
  logic [COLOR_W-1:0] color_n;

  // Color is classified from the next index so it registers alongside fb_addr.
  sga_cell_classifier #(.CELLS(CELLS), .AW(AW), .COLOR_W(COLOR_W)) u_classifier (
    .idx         (idx_n),
    .head        (head_n),
    .apple       (apple_n),
    .apple_valid (av_n),
    .body_map    (body_map),
    .color       (color_n)
  );

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    cred_n  = cred_q;
    head_n  = head_q;
    apple_n = apple_q;
    av_n    = av_q;
    adv     = 1'b0;
    inc     = 1'b0;
    if (render_clr) begin
      head_n  = head_pos;
      apple_n = apple_pos;
      av_n    = apple_valid;
      idx_n   = '0;
      cred_n  = '0;
      state_n = ST_WRITE;
    end else begin
      unique case (state_q)
        ST_WRITE: begin
          inc = render_count;
          if (fb_ready) begin
            if (idx_q == LAST)                          state_n = ST_DONE;
            else if (cred_q != '0 || render_count)      adv = 1'b1;
            else                                        state_n = ST_WAIT;
          end
        end
        ST_WAIT: begin
          inc = render_count;
          if (cred_q != '0 || render_count) begin
            adv     = 1'b1;
            state_n = ST_WRITE;
          end
        end
        default: ;
      endcase
      // A grant and an advance in the same cycle cancel out.
      if (inc && !adv) begin
        if (cred_q != LAST) cred_n = cred_q + AW'(1);
      end else if (!inc && adv) begin
        cred_n = cred_q - AW'(1);
      end
      if (adv) idx_n = idx_q + AW'(1);
    end
  end

  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      cred_q        <= '0;
      head_q        <= '0;
      apple_q       <= '0;
      av_q          <= 1'b0;
      fb_valid      <= 1'b0;
      fb_addr       <= '0;
      fb_color      <= '0;
      render_finish <= 1'b0;
    end else begin
      state_q       <= state_n;
      idx_q         <= idx_n;
      cred_q        <= cred_n;
      head_q        <= head_n;
      apple_q       <= apple_n;
      av_q          <= av_n;
      fb_valid      <= (state_n == ST_WRITE);
      fb_addr       <= idx_n;
      fb_color      <= color_n;
      render_finish <= (state_n == ST_DONE);
    end
  end

  assign db_state = state_q;

endmodule

// File: tb/tb_sga_render_engine.sv
// Directed self-checking bench for sga_render_engine on a 4x4 board.
module tb_sga_render_engine;

  localparam int unsigned CELLS = 16;
  localparam int unsigned AW    = 4;

  logic             clock = 1'b0;
  logic             restart = 1'b1;
  logic             render_clr = 1'b0;
  logic             render_count = 1'b0;
  logic [AW-1:0]    head_pos = '0;
  logic [AW-1:0]    apple_pos = '0;
  logic             apple_valid = 1'b0;
  logic [CELLS-1:0] body_map = '0;
  logic             fb_ready = 1'b0;
  logic             fb_valid;
  logic [AW-1:0]    fb_addr;
  logic [1:0]       fb_color;
  logic             render_finish;
  logic [1:0]       db_state;

  int tests = 0;
  int failed = 0;
  logic [AW-1:0] mon_addr[$];
  logic [1:0]    mon_color[$];

  sga_render_engine #(.ROWS(4), .COLS(4), .COLOR_W(2)) dut (
    .clock         (clock),
    .restart       (restart),
    .render_clr    (render_clr),
    .render_count  (render_count),
    .head_pos      (head_pos),
    .apple_pos     (apple_pos),
    .apple_valid   (apple_valid),
    .body_map      (body_map),
    .fb_ready      (fb_ready),
    .fb_valid      (fb_valid),
    .fb_addr       (fb_addr),
    .fb_color      (fb_color),
    .render_finish (render_finish),
    .db_state      (db_state)
  );

  always #5 clock = ~clock;

  // Record every accepted beat; inputs only change just after rising edges.
  always @(negedge clock) begin
    if (!restart && fb_valid && fb_ready) begin
      mon_addr.push_back(fb_addr);
      mon_color.push_back(fb_color);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_color(input int i, input int h, input int a,
                                             input logic av, input logic [CELLS-1:0] b);
    if (i == h)           return 2'd2;
    if (av && i == a)     return 2'd3;
    if (b[i])             return 2'd1;
    return 2'd0;
  endfunction

  task automatic clear_mon();
    mon_addr.delete();
    mon_color.delete();
  endtask

  task automatic start_frame();
    render_clr = 1'b1;
    tick();
    render_clr = 1'b0;
  endtask

  task automatic run_to_done(input string tag);
    for (int k = 0; k < 200 && !render_finish; k++) begin
      render_count = k[0];
      tick();
    end
    render_count = 1'b0;
    check(tag, 32'(render_finish), 32'd1);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_beats"}, 32'(mon_addr.size()), 32'd16);
    for (int i = 0; i < mon_addr.size() && i < 16; i++) begin
      check({tag, "_addr"}, 32'(mon_addr[i]), 32'(i));
      check({tag, "_color"}, 32'(mon_color[i]),
            32'(model_color(i, int'(head_pos), int'(apple_pos), apple_valid, body_map)));
    end
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", 32'(fb_valid), 32'd0);
    check("rst_finish", 32'(render_finish), 32'd0);
    check("rst_state", 32'(db_state), 32'd0);
    check("rst_addr", 32'(fb_addr), 32'd0);
    check("rst_color", 32'(fb_color), 32'd0);
    restart = 1'b0;
    tick();
    check("idle_state", 32'(db_state), 32'd0);

    // Full frame, counts every other cycle
    head_pos = 4'd5; apple_pos = 4'd9; apple_valid = 1'b1; body_map = 16'h0030;
    fb_ready = 1'b1;
    clear_mon();
    start_frame();
    check("f_valid0", 32'(fb_valid), 32'd1);
    check("f_addr0", 32'(fb_addr), 32'd0);
    check("f_finish0", 32'(render_finish), 32'd0);
    check("f_state0", 32'(db_state), 32'd1);
    tick();
    check("f_wait_state", 32'(db_state), 32'd2);
    check("f_wait_valid", 32'(fb_valid), 32'd0);
    render_count = 1'b1; tick(); render_count = 1'b0;
    for (int i = 1; i < 15; i++) begin
      tick();
      render_count = 1'b1; tick(); render_count = 1'b0;
    end
    check("f_last_addr", 32'(fb_addr), 32'd15);
    check("f_last_finish", 32'(render_finish), 32'd0);
    tick();
    check("f_finish", 32'(render_finish), 32'd1);
    check("f_done_state", 32'(db_state), 32'd3);
    check_frame("frame");
    if (mon_color.size() == 16) begin
      check("f_c5_head", 32'(mon_color[5]), 32'd2);
      check("f_c4_body", 32'(mon_color[4]), 32'd1);
      check("f_c9_apple", 32'(mon_color[9]), 32'd3);
      check("f_c0_empty", 32'(mon_color[0]), 32'd0);
    end

    // Backpressure at addr 2 with counts arriving meanwhile
    body_map = 16'h0004;
    clear_mon();
    start_frame();
    render_count = 1'b1;
    tick(); tick();
    check("bp_addr2", 32'(fb_addr), 32'd2);
    fb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_addr", 32'(fb_addr), 32'd2);
      check("bp_hold_color", 32'(fb_color), 32'd1);
      check("bp_hold_valid", 32'(fb_valid), 32'd1);
    end
    fb_ready = 1'b1;
    tick();
    render_count = 1'b0;
    check("bp_rel_addr", 32'(fb_addr), 32'd3);
    tick(); tick(); tick();
    check("bp_b2b_addr", 32'(fb_addr), 32'd6);
    check("bp_b2b_valid", 32'(fb_valid), 32'd1);
    tick();
    check("bp_credits_spent", 32'(db_state), 32'd2);
    check("bp_wait_addr", 32'(fb_addr), 32'd6);
    run_to_done("bp_done");
    check_frame("bp");

    // Priority: head over apple over body
    head_pos = 4'd7; apple_pos = 4'd7; apple_valid = 1'b1; body_map = 16'h0080;
    clear_mon();
    start_frame();
    run_to_done("pri1_done");
    check_frame("pri1");
    if (mon_color.size() == 16) check("pri_head_wins", 32'(mon_color[7]), 32'd2);
    head_pos = 4'd12; apple_pos = 4'd3; apple_valid = 1'b0; body_map = 16'h0000;
    clear_mon();
    start_frame();
    run_to_done("pri2_done");
    check_frame("pri2");
    if (mon_color.size() == 16) check("pri_apple_off", 32'(mon_color[3]), 32'd0);

    // Abort mid-beat at addr 10, with a coincident count that must be dropped
    head_pos = 4'd5; apple_pos = 4'd9; apple_valid = 1'b1; body_map = 16'h0030;
    start_frame();
    render_count = 1'b1;
    repeat (10) tick();
    render_count = 1'b0;
    check("ab_addr10", 32'(fb_addr), 32'd10);
    fb_ready = 1'b0;
    tick();
    check("ab_stall", 32'(fb_addr), 32'd10);
    clear_mon();
    render_clr = 1'b1; render_count = 1'b1;
    tick();
    render_clr = 1'b0; render_count = 1'b0;
    check("ab_valid", 32'(fb_valid), 32'd1);
    check("ab_addr0", 32'(fb_addr), 32'd0);
    check("ab_state", 32'(db_state), 32'd1);
    fb_ready = 1'b1;
    tick();
    check("ab_no_credit", 32'(db_state), 32'd2);
    run_to_done("ab_done");
    check_frame("abort");

    // Counts in DONE are ignored; the next clear restarts cleanly
    clear_mon();
    for (int i = 0; i < 5; i++) begin
      render_count = 1'b1; tick(); render_count = 1'b0; tick();
    end
    check("done_no_writes", 32'(mon_addr.size()), 32'd0);
    check("done_sticky", 32'(render_finish), 32'd1);
    check("done_state", 32'(db_state), 32'd3);
    start_frame();
    check("re_finish", 32'(render_finish), 32'd0);
    check("re_valid", 32'(fb_valid), 32'd1);
    check("re_addr", 32'(fb_addr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
